// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: one shift-add (multiply) or one restoring
// subtract (divide) step per cycle. A fixed WIDTH-cycle RUN phase is followed
// by a one-cycle DONE pulse. Signed operations run on magnitudes, and the sign
// is fixed up as the result is written.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mcop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             divzero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;   // 1: divide, 0: multiply
  logic             neg_q;      // product / quotient must be negated
  logic             rneg_q;     // remainder must be negated (dividend sign)
  logic             dz_q;       // divide with zero divisor
  logic [WIDTH-1:0] araw_q;     // original dividend, returned on divide-by-zero
  logic [WIDTH-1:0] opb_q;      // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] mq_q;       // multiplier/product-low (mul) or dividend/quotient (div)
  logic [WIDTH:0]   acc_q;      // product-high (mul) or partial remainder (div)

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   acc_nxt, sum, shifted;
  logic [WIDTH-1:0] mq_nxt, quo, rem;
  logic             qbit;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] res_lo_d, res_hi_d;

  assign accept = start && (state_q != RUN);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes for the signed variants
  always_comb begin
    a_neg = mcop[0] & a[WIDTH-1];
    b_neg = mcop[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    acc_nxt = acc_q;
    mq_nxt  = mq_q;
    sum     = '0;
    shifted = '0;
    qbit    = 1'b0;
    if (is_div_q) begin
      shifted = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
      if (shifted >= {1'b0, opb_q}) begin
        acc_nxt = shifted - {1'b0, opb_q};
        qbit    = 1'b1;
      end else begin
        acc_nxt = shifted;
      end
      mq_nxt = {mq_q[WIDTH-2:0], qbit};
    end else begin
      sum     = mq_q[0] ? (acc_q + {1'b0, opb_q}) : acc_q;
      acc_nxt = sum >> 1;
      mq_nxt  = {sum[0], mq_q[WIDTH-1:1]};
    end
  end

  // Sign correction and special cases, applied to the final iteration's values
  always_comb begin
    prod     = {acc_nxt[WIDTH-1:0], mq_nxt};
    prod_fix = neg_q ? -prod : prod;
    quo      = neg_q ? -mq_nxt : mq_nxt;
    rem      = rneg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    res_lo_d = prod_fix[WIDTH-1:0];
    res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      if (dz_q) begin
        res_lo_d = '1;
        res_hi_d = araw_q;
      end else begin
        res_lo_d = quo;
        res_hi_d = rem;
      end
    end
  end

  // Operand capture, iteration registers and result write on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      araw_q    <= '0;
      opb_q     <= '0;
      mq_q      <= '0;
      acc_q     <= '0;
      result_lo <= '0;
      result_hi <= '0;
      divzero   <= 1'b0;
    end else if (accept) begin
      cnt_q    <= CW'(WIDTH - 1);
      is_div_q <= mcop[1];
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      dz_q     <= mcop[1] && (b == '0);
      araw_q   <= a;
      opb_q    <= mcop[1] ? b_mag : a_mag;
      mq_q     <= mcop[1] ? a_mag : b_mag;
      acc_q    <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_nxt;
      mq_q  <= mq_nxt;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) begin
        result_lo <= res_lo_d;
        result_hi <= res_hi_d;
        divzero   <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: a 32-bit instance for the bulk of the cases
// and an 8-bit instance for the narrow-width multiply.
module tb_mcycle_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mcop;
  logic [31:0] a, b;
  logic        busy, done, divzero;
  logic [31:0] result_lo, result_hi;

  logic        start8;
  logic [1:0]  mcop8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, divzero8;
  logic [7:0]  lo8, hi8;

  int nchk = 0;
  int nerr = 0;
  int lat, bcnt;

  always #5 clk = ~clk;

  mcycle_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mcop(mcop), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .divzero(divzero)
  );

  mcycle_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mcop(mcop8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8),
    .divzero(divzero8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an operation and clock it in; returns in cycle 1 after the start edge
  task automatic launch(input logic [1:0] op, input logic [31:0] aa, input logic [31:0] bb);
    mcop  = op;
    a     = aa;
    b     = bb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0BAD_F00D;
    mcop  = 2'b11;
  endtask

  // Wait (bounded) for done; first is the cycle index of the current cycle
  task automatic wait_done(input int first, output int l, output int bc);
    l  = 0;
    bc = 0;
    for (int i = first; i <= first + 45; i++) begin
      if (busy) bc++;
      if (done) begin
        l = i;
        break;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; mcop = 2'b00; a = '0; b = '0;
    start8 = 1'b0; mcop8 = 2'b00; a8 = '0; b8 = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state held over idle cycles
    for (int i = 0; i < 5; i++) tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_res", {result_hi, result_lo}, 64'd0);
    chk("rst_dz", {63'd0, divzero}, 64'd0);

    // Reset wins over start in the same cycle
    mcop = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    chk("rst_wins_busy", {63'd0, busy}, 64'd0);

    // Reset in RUN cycle 10 aborts with no done pulse
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 1; i < 10; i++) tick();
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    wait_done(1, lat, bcnt);
    chk("abort_no_done", 64'(lat), 64'd0);
    chk("abort_res", {result_hi, result_lo}, 64'd0);

    // Unsigned multiply, max operands: latency and busy window
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, lat, bcnt);
    chk("umul_lat", 64'(lat), 64'd33);
    chk("umul_busy", 64'(bcnt), 64'd32);
    chk("umul_res", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    chk("umul_dz", {63'd0, divzero}, 64'd0);
    tick();
    chk("done_pulse", {63'd0, done}, 64'd0);

    // Signed and unsigned multiply of -7 * 6
    launch(2'b01, 32'hFFFF_FFF9, 32'd6);
    wait_done(1, lat, bcnt);
    chk("smul_res", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFD6);
    launch(2'b00, 32'hFFFF_FFF9, 32'd6);
    wait_done(1, lat, bcnt);
    chk("umul2_res", {result_hi, result_lo}, 64'h0000_0005_FFFF_FFD6);

    // Signed divide -7 / 2
    launch(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, lat, bcnt);
    chk("sdiv_lat", 64'(lat), 64'd33);
    chk("sdiv_res", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // Unsigned divide 100 / 7
    launch(2'b10, 32'd100, 32'd7);
    wait_done(1, lat, bcnt);
    chk("udiv_res", {result_hi, result_lo}, 64'h0000_0002_0000_000E);
    chk("udiv_dz", {63'd0, divzero}, 64'd0);

    // Unsigned divide by zero
    launch(2'b10, 32'h0000_1234, 32'd0);
    wait_done(1, lat, bcnt);
    chk("div0_lat", 64'(lat), 64'd33);
    chk("div0_dz", {63'd0, divzero}, 64'd1);
    chk("div0_res", {result_hi, result_lo}, 64'h0000_1234_FFFF_FFFF);

    // Signed divide by zero returns the dividend unmodified
    launch(2'b11, 32'hFFFF_FFFB, 32'd0);
    wait_done(1, lat, bcnt);
    chk("sdiv0_dz", {63'd0, divzero}, 64'd1);
    chk("sdiv0_res", {result_hi, result_lo}, 64'hFFFF_FFFB_FFFF_FFFF);

    // Signed overflow: most-negative / -1
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, lat, bcnt);
    chk("sovf_res", {result_hi, result_lo}, 64'h0000_0000_8000_0000);
    chk("sovf_dz", {63'd0, divzero}, 64'd0);

    // Back-to-back: start held through the done cycle
    launch(2'b00, 32'h0001_0000, 32'h0001_0000);
    wait_done(1, lat, bcnt);
    chk("b2b_first", {result_hi, result_lo}, 64'h0000_0001_0000_0000);
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_accept_busy", {63'd0, busy}, 64'd1);
    chk("b2b_hold", {result_hi, result_lo}, 64'h0000_0001_0000_0000);
    wait_done(1, lat, bcnt);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_second", {result_hi, result_lo}, 64'h0000_0000_0000_0001);

    // Start pulsed mid-RUN is ignored
    tick();
    launch(2'b10, 32'd1000, 32'd9);
    for (int i = 1; i < 5; i++) tick();
    mcop = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(6, lat, bcnt);
    chk("midrun_lat", 64'(lat), 64'd33);
    chk("midrun_res", {result_hi, result_lo}, 64'h0000_0001_0000_006F);
    tick();
    chk("midrun_idle", {62'd0, busy, done}, 64'd0);

    // 8-bit instance: 0xFF * 0xFF unsigned
    mcop8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy8) bcnt++;
      if (done8) begin
        lat = i;
        break;
      end
      tick();
    end
    chk("w8_lat", 64'(lat), 64'd9);
    chk("w8_busy", 64'(bcnt), 64'd8);
    chk("w8_res", {48'd0, hi8, lo8}, 64'h0000_0000_0000_FE01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
